// File: rtl/axis_red_pitaya_dac_sink.sv
// AXI4-Stream slave feeding the interleaved two-channel Red Pitaya DAC (A then B per pair).
// Define DAC_UNDERFLOW_CNT_EN to add the saturating underflow_cnt[15:0] output.
`timescale 1ns/1ps
module axis_red_pitaya_dac_sink #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned DAC_DATA_WIDTH   = 14,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DAC_DATA_WIDTH-1:0]   dac_dat,
    output logic                        dac_sel,
    output logic                        dac_wrt,
    output logic                        dac_rst,
    output logic                        underflow
`ifdef DAC_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                 underflow_cnt
`endif
);
    localparam int unsigned LW = AXIS_TDATA_WIDTH / 2;
    localparam int unsigned DW = DAC_DATA_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    function automatic logic [DW-1:0] conv(input logic [LW-1:0] lane);
        return {~lane[LW-1], lane[LW-2 -: DW-1]};
    endfunction

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic              uf_pair_q, uf_pair_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic              sel_q, sel_d;
    logic              wrt_q, wrt_d;
    logic              rst_q, rst_d;
    logic              underflow_q, underflow_d;

    logic [2*DW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [2*DW-1:0]   head;
    logic              push, pop, fifo_full, fifo_empty;
    logic              unused_lsbs;

    assign unused_lsbs = ^{s_axis_tdata[LW+(LW-DW)-1:LW], s_axis_tdata[LW-DW-1:0]};

    assign fifo_full     = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty    = (count_q == '0);
    assign s_axis_tready = !fifo_full && (state_q != IDLE);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign head          = mem_q[rd_ptr_q];

    assign dac_dat   = dat_q;
    assign dac_sel   = sel_q;
    assign dac_wrt   = wrt_q;
    assign dac_rst   = rst_q;
    assign underflow = underflow_q;

    // Lanes are converted on entry so the FIFO holds ready-to-drive DAC codes {B, A}.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= {conv(s_axis_tdata[2*LW-1:LW]), conv(s_axis_tdata[LW-1:0])};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (state_q == IDLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        uf_pair_d   = uf_pair_q;
        hold_d      = hold_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        wrt_d       = wrt_q;
        rst_d       = rst_q;
        underflow_d = underflow_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                dat_d     = MIDSCALE;
                sel_d     = 1'b0;
                wrt_d     = 1'b0;
                rst_d     = 1'b1;
                phase_d   = 1'b0;
                uf_pair_d = 1'b0;
                if (enable) begin
                    state_d     = PRIME;
                    underflow_d = 1'b0;
                end
            end
            PRIME: begin
                dat_d     = MIDSCALE;
                sel_d     = 1'b0;
                wrt_d     = 1'b0;
                rst_d     = 1'b0;
                phase_d   = 1'b0;
                uf_pair_d = 1'b0;
                if (!enable)                               state_d = IDLE;
                else if (count_q >= CW'(FIFO_DEPTH / 2))   state_d = RUN;
            end
            RUN: begin
                rst_d   = 1'b0;
                wrt_d   = 1'b1;
                phase_d = !phase_q;
                if (!phase_q) begin
                    sel_d = 1'b0;
                    if (fifo_empty) begin
                        dat_d       = MIDSCALE;
                        uf_pair_d   = 1'b1;
                        underflow_d = 1'b1;
                    end else begin
                        pop       = 1'b1;
                        dat_d     = head[DW-1:0];
                        hold_d    = head[2*DW-1:DW];
                        uf_pair_d = 1'b0;
                    end
                end else begin
                    // Pair boundary: enable and underflow recovery are only honoured here.
                    sel_d = 1'b1;
                    dat_d = uf_pair_q ? MIDSCALE : hold_q;
                    if (!enable)        state_d = IDLE;
                    else if (uf_pair_q) state_d = PRIME;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            uf_pair_q   <= 1'b0;
            hold_q      <= '0;
            dat_q       <= MIDSCALE;
            sel_q       <= 1'b0;
            wrt_q       <= 1'b0;
            rst_q       <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            uf_pair_q   <= uf_pair_d;
            hold_q      <= hold_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            wrt_q       <= wrt_d;
            rst_q       <= rst_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef DAC_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (state_q == IDLE && enable)
            ucnt_d = '0;
        else if (state_q == RUN && !phase_q && fifo_empty && ucnt_q != '1)
            ucnt_d = ucnt_q + 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ucnt_q <= '0;
        else          ucnt_q <= ucnt_d;
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule
